uart_tx_buffered: RTL and testbench
===================================

// Module: uart_tx_buffered
// PURPOSE
//  Buffered UART transmitter for the console path: CPU/PIA side pushes bytes into a FIFO,
//  block serialises them 8N1/8N2 on txd with optional CTS flow control.
//  Sits between the Apple-1 display/PIA output logic and the board's serial TX pin.
//  Frees the producer from polling a busy flag per character. Has its own fractional baud tick.
// PARAMETERS
//  CLK_FREQ    25000000  clk frequency in Hz
//  BAUD        115200    line rate in bit/s
//  FIFO_DEPTH  16        entries; power of 2, >= 2
//  STOP_BITS   2         1 or 2
//  USE_CTS     1         1: cts_n gates frame starts; 0: cts_n ignored
// PORTS
//  clk       in   1     clock
//  rst       in   1     asynchronous reset, active-high
//  wr_en     in   1     push wr_data when !full
//  wr_data   in   8     byte to transmit, LSB first on the line
//  full      out  1     FIFO holds FIFO_DEPTH entries
//  empty     out  1     FIFO holds 0 entries
//  level     out  AW+1  entry count, AW = log2(FIFO_DEPTH)
//  overflow  out  1     sticky: write attempted while full
//  ovf_clr   in   1     clears overflow
//  cts_n     in   1     async clear-to-send, active-low
//  txd       out  1     serial out, idle high
//  busy      out  1     frame in progress (state != IDLE)
// BEHAVIOUR
//  Reset: txd=1, busy=0, full=0, empty=1, level=0, overflow=0; FIFO pointers 0, FSM IDLE.
//   Reset mid-frame aborts it, txd returns high immediately, queued data discarded.
//  Baud tick: 16-bit phase accumulator, INC = round(BAUD*2^16/CLK_FREQ); tick on carry.
//   Accumulator held at 0 in IDLE so the start bit is full-width. Bit period = CLK_FREQ/BAUD
//   +/-1 clk (217/218 clk at defaults); cumulative drift over a frame < 1 clk.
//  FIFO: write accepted iff wr_en && !full (full is pre-edge value; a same-cycle pop does
//   not make room). Rejected write sets overflow; ovf_clr clears it; set wins if both.
//   Same-cycle write+pop with level>=1: both occur, level unchanged.
//  cts_n: 2-flop synchroniser. Frame may start only if USE_CTS==0 or synced cts_n==0.
//   Deasserting CTS never aborts a frame in flight.
//  FSM (all outputs registered):
//   IDLE : if !empty && cts_ok -> START; pop head into shift reg same edge; txd<=0.
//   START: txd=0 one bit period; on tick -> DATA, bitcnt=0, txd<=shift[0].
//   DATA : on tick shift right, bitcnt++; after bit 7 -> STOP, txd<=1.
//   STOP : STOP_BITS periods high; on last tick: if !empty && cts_ok -> START (pop,
//          txd<=0, no idle gap), else -> IDLE.
//  Latency: wr_en accepted at edge N into empty FIFO, IDLE: empty deasserts after N,
//   txd falls after edge N+1 (two clocks wr_en->start bit).
//  Back-to-back frames: exactly 9+STOP_BITS bit periods each, no extra idle.
//  level/full/empty/overflow update on the edge of the write/pop; no combinational paths
//   from inputs to outputs.
// STRUCTURE
//  Shared header uart_defs.vh: FSM state encodings, ACC_W=16, INC calc function,
//   log2 function (shared with other UART blocks).
//  One sub-module: sync_fifo (DEPTH, WIDTH=8; wr_en/rd_en, dout=head, full/empty/level;
//   extra pointer bit for full/empty). Baud accumulator, synchroniser and FSM stay top-level.
// TESTING
//  1. Idle, write 0x55 -> txd low 2 clk later; bits 1,0,1,0,1,0,1,0; 2 stop highs;
//     each bit 217/218 clk; busy high whole frame, then IDLE, txd=1.
//  2. 17 writes on consecutive clks with cts_n=1 -> full after 16th, 17th dropped,
//     overflow=1, level=16; ovf_clr -> overflow=0; cts_n=0 -> 16 frames, no gaps, order kept.
//  3. Mid-frame cts_n=1 -> current frame finishes, txd stays high, level unchanged;
//     cts_n=0 -> next start bit within 3 clk + synchroniser.
//  4. level=1 during STOP last tick, write same cycle as pop -> level stays 1,
//     next frame starts immediately, written byte follows.
//  5. Assert rst during DATA bit 4 -> txd=1, busy=0, empty=1, level=0 immediately;
//     after release, write 0xA3 -> clean frame 1,1,0,0,0,1,0,1.
//  6. STOP_BITS=1, USE_CTS=0 build: 0x00 then 0xFF back-to-back -> 10-bit frames, cts_n ignored.

Source files
------------

// File: rtl/uart_tx_buffered_pkg.sv
// Shared UART definitions: TX FSM states, accumulator width,
// baud increment and log2 helpers.
package uart_tx_buffered_pkg;

    localparam int ACC_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } txState_t;

    // round(baud * 2^ACC_W / clkFreq)
    function automatic int calcInc(input longint clkFreq, input longint baud);
        longint num;
        num = baud * (longint'(1) << ACC_W) + clkFreq / 2;
        return int'(num / clkFreq);
    endfunction

    function automatic int clog2Int(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_buffered_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head output.
// Extra pointer bit separates full from empty.
module uart_tx_buffered_sync_fifo
    import uart_tx_buffered_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           din,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [clog2Int(DEPTH):0]   level
);

    localparam int AW = clog2Int(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wrPtr;
    logic [AW:0]      rdPtr;
    logic             doWr;
    logic             doRd;

    assign doWr  = wr_en && !full;
    assign doRd  = rd_en && !empty;
    assign empty = (wrPtr == rdPtr);
    assign full  = (wrPtr[AW] != rdPtr[AW]) &&
                   (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign level = wrPtr - rdPtr;
    assign dout  = mem[rdPtr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (doWr) mem[wrPtr[AW-1:0]] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doWr) wrPtr <= wrPtr + 1'b1;
            if (doRd) rdPtr <= rdPtr + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1/8N2 UART transmitter with fractional baud tick
// and optional CTS gating of frame starts.
module uart_tx_buffered
    import uart_tx_buffered_pkg::*;
#(
    parameter int CLK_FREQ   = 25000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16,
    parameter int STOP_BITS  = 2,
    parameter int USE_CTS    = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wr_en,
    input  logic [7:0]                      wr_data,
    output logic                            full,
    output logic                            empty,
    output logic [clog2Int(FIFO_DEPTH):0]   level,
    output logic                            overflow,
    input  logic                            ovf_clr,
    input  logic                            cts_n,
    output logic                            txd,
    output logic                            busy
);

    localparam logic [ACC_W-1:0] INC = ACC_W'(calcInc(CLK_FREQ, BAUD));

    txState_t       state;
    txState_t       stateNext;
    logic [ACC_W-1:0] acc;
    logic [ACC_W:0] accSum;
    logic           tick;
    logic           ctsMeta;
    logic           ctsSync;
    logic           ctsOk;
    logic           fifoEmpty;
    logic [7:0]     fifoDout;
    logic           pop;
    logic [7:0]     shiftReg;
    logic [7:0]     shiftNext;
    logic [2:0]     bitCnt;
    logic [2:0]     bitCntNext;
    logic           stopCnt;
    logic           stopCntNext;
    logic           lastStop;
    logic           txdNext;

    uart_tx_buffered_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (wr_en),
        .din   (wr_data),
        .rd_en (pop),
        .dout  (fifoDout),
        .full  (full),
        .empty (fifoEmpty),
        .level (level)
    );

    assign empty    = fifoEmpty;
    assign busy     = (state != IDLE);
    assign accSum   = {1'b0, acc} + {1'b0, INC};
    assign tick     = accSum[ACC_W];
    assign ctsOk    = (USE_CTS == 0) || !ctsSync;
    assign lastStop = (STOP_BITS == 1) || stopCnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctsMeta <= 1'b1;
            ctsSync <= 1'b1;
        end else begin
            ctsMeta <= cts_n;
            ctsSync <= ctsMeta;
        end
    end

    // Set wins over clear so a rejected write is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) overflow <= 1'b0;
        else if (wr_en && full) overflow <= 1'b1;
        else if (ovf_clr) overflow <= 1'b0;
    end

    // Held at zero while idle so every start bit is full width.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) acc <= '0;
        else if (state == IDLE) acc <= '0;
        else acc <= accSum[ACC_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            txd      <= 1'b1;
            shiftReg <= '0;
            bitCnt   <= '0;
            stopCnt  <= 1'b0;
        end else begin
            state    <= stateNext;
            txd      <= txdNext;
            shiftReg <= shiftNext;
            bitCnt   <= bitCntNext;
            stopCnt  <= stopCntNext;
        end
    end

    always_comb begin
        stateNext   = state;
        txdNext     = txd;
        shiftNext   = shiftReg;
        bitCntNext  = bitCnt;
        stopCntNext = stopCnt;
        pop         = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifoEmpty && ctsOk) begin
                    stateNext = START;
                    pop       = 1'b1;
                    shiftNext = fifoDout;
                    txdNext   = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    stateNext  = DATA;
                    bitCntNext = '0;
                    txdNext    = shiftReg[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (bitCnt == 3'd7) begin
                        stateNext   = STOP;
                        stopCntNext = 1'b0;
                        txdNext     = 1'b1;
                    end else begin
                        shiftNext  = {1'b0, shiftReg[7:1]};
                        bitCntNext = bitCnt + 3'd1;
                        txdNext    = shiftReg[1];
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (!lastStop) begin
                        stopCntNext = 1'b1;
                    end else if (!fifoEmpty && ctsOk) begin
                        stateNext = START;
                        pop       = 1'b1;
                        shiftNext = fifoDout;
                        txdNext   = 1'b0;
                    end else begin
                        stateNext = IDLE;
                    end
                end
            end
            default: begin
                stateNext = IDLE;
                txdNext   = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered: default build plus an
// 8N1 build with CTS ignored.
module tb_uart_tx_buffered;

    logic       clk = 1'b0;
    logic       rst;
    logic       wrEn, ovfClr, ctsN;
    logic [7:0] wrData;
    logic       full0, empty0, ovf0, txd0, busy0;
    logic [4:0] level0;
    logic       wrEn1, ovfClr1, ctsN1;
    logic [7:0] wrData1;
    logic       full1, empty1, ovf1, txd1, busy1;
    logic [4:0] level1;
    logic       sel;
    logic       txdMon, busyMon;
    int         checks = 0;
    int         failures = 0;
    int         n;
    logic       ok;
    logic [7:0] pat;
    logic       val;

    always #5 clk = ~clk;

    uart_tx_buffered dut0 (
        .clk(clk), .rst(rst), .wr_en(wrEn), .wr_data(wrData),
        .full(full0), .empty(empty0), .level(level0),
        .overflow(ovf0), .ovf_clr(ovfClr), .cts_n(ctsN),
        .txd(txd0), .busy(busy0)
    );

    uart_tx_buffered #(.STOP_BITS(1), .USE_CTS(0)) dut1 (
        .clk(clk), .rst(rst), .wr_en(wrEn1), .wr_data(wrData1),
        .full(full1), .empty(empty1), .level(level1),
        .overflow(ovf1), .ovf_clr(ovfClr1), .cts_n(ctsN1),
        .txd(txd1), .busy(busy1)
    );

    assign txdMon  = sel ? txd1 : txd0;
    assign busyMon = sel ? busy1 : busy0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkRange(input string tag, input int v,
                            input int lo, input int hi);
        checks++;
        assert (v >= lo && v <= hi) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, v, lo, hi);
        end
    endtask

    task automatic waitStart(input string tag, input int limit,
                             output int cnt);
        cnt = 0;
        while (txdMon !== 1'b0 && cnt < limit) begin
            @(negedge clk);
            cnt++;
        end
        checks++;
        assert (txdMon === 1'b0) else begin
            failures++;
            $error("FAIL %s: observed no start bit expected one within %0d clk",
                   tag, limit);
        end
    endtask

    // Called on the negedge where the start bit is first seen.
    task automatic rxFrame(input int sb, output logic [7:0] data,
                           output logic fmOk, output int len);
        int idx;
        data = '0;
        fmOk = 1'b1;
        len  = 0;
        for (int c = 1; c <= 3000; c++) begin
            @(negedge clk);
            if (c % 217 == 108) begin
                idx = c / 217;
                if (idx == 0) fmOk &= (txdMon === 1'b0);
                else if (idx <= 8) data[idx-1] = txdMon;
                else if (idx <= 8 + sb) fmOk &= (txdMon === 1'b1);
            end
            if (c > (8 + sb) * 217 + 120 &&
                (txdMon === 1'b0 || busyMon === 1'b0)) begin
                len = c;
                break;
            end
            if (busyMon !== 1'b1) fmOk = 1'b0;
        end
    endtask

    task automatic frame(input string tag, input int sb,
                         input logic [7:0] exp, input logic expNext);
        logic [7:0] d;
        logic       fok;
        int         len;
        rxFrame(sb, d, fok, len);
        chk({tag, "_data"}, 32'(d), 32'(exp));
        chk({tag, "_fmt"}, 32'(fok), 32'd1);
        chkRange({tag, "_len"}, len, (9 + sb) * 217, (9 + sb) * 217 + 2);
        chk({tag, "_next"}, 32'(txdMon === 1'b0), 32'(expNext));
    endtask

    initial begin
        rst = 1'b1;
        wrEn = 1'b0; wrData = '0; ovfClr = 1'b0; ctsN = 1'b0;
        wrEn1 = 1'b0; wrData1 = '0; ovfClr1 = 1'b0; ctsN1 = 1'b1;
        sel = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_txd", 32'(txd0), 32'd1);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_full", 32'(full0), 32'd0);
        chk("rst_empty", 32'(empty0), 32'd1);
        chk("rst_level", 32'(level0), 32'd0);
        chk("rst_ovf", 32'(ovf0), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // single 0x55 frame, latency and per-bit widths
        wrEn = 1'b1; wrData = 8'h55;
        @(negedge clk);
        wrEn = 1'b0;
        chk("t1_empty_n", 32'(empty0), 32'd0);
        chk("t1_txd_n", 32'(txd0), 32'd1);
        chk("t1_level_n", 32'(level0), 32'd1);
        @(negedge clk);
        chk("t1_txd_n1", 32'(txd0), 32'd0);
        chk("t1_busy", 32'(busy0), 32'd1);
        chk("t1_level_n1", 32'(level0), 32'd0);
        pat = 8'h55;
        for (int p = 0; p < 9; p++) begin
            val = (p == 0) ? 1'b0 : pat[p-1];
            n = 0;
            while (txd0 === val && n < 300) begin
                @(negedge clk);
                n++;
            end
            chkRange("t1_bitw", n, 217, 218);
            chk("t1_busy_bit", 32'(busy0), 32'd1);
        end
        n = 0;
        while (busy0 === 1'b1 && n < 500) begin
            @(negedge clk);
            chk("t1_stop_txd", 32'(txd0), 32'd1);
            n++;
        end
        chkRange("t1_stopw", n, 434, 436);
        chk("t1_idle_txd", 32'(txd0), 32'd1);
        chk("t1_idle_empty", 32'(empty0), 32'd1);

        // fill past full with CTS held off, then drain
        ctsN = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            wrEn = 1'b1;
            wrData = 8'(8'h10 + i);
            @(negedge clk);
            if (i == 15) begin
                chk("t2_full16", 32'(full0), 32'd1);
                chk("t2_level16", 32'(level0), 32'd16);
                chk("t2_ovf16", 32'(ovf0), 32'd0);
            end
        end
        wrEn = 1'b0;
        chk("t2_ovf", 32'(ovf0), 32'd1);
        chk("t2_level", 32'(level0), 32'd16);
        chk("t2_busy", 32'(busy0), 32'd0);
        chk("t2_txd", 32'(txd0), 32'd1);
        ovfClr = 1'b1;
        @(negedge clk);
        ovfClr = 1'b0;
        chk("t2_ovf_clr", 32'(ovf0), 32'd0);
        ctsN = 1'b0;
        waitStart("t2_start", 6, n);
        for (int i = 0; i < 16; i++) begin
            frame("t2", 2, 8'(8'h10 + i), i < 15);
        end
        chk("t2_empty", 32'(empty0), 32'd1);

        // CTS withdrawn mid-frame
        wrEn = 1'b1; wrData = 8'hC3;
        @(negedge clk);
        wrData = 8'h3C;
        @(negedge clk);
        wrEn = 1'b0;
        chk("t3_start", 32'(txd0), 32'd0);
        ctsN = 1'b1;
        chk("t3_level", 32'(level0), 32'd1);
        frame("t3a", 2, 8'hC3, 1'b0);
        ok = 1'b1;
        repeat (400) begin
            @(negedge clk);
            ok &= (txd0 === 1'b1) && (busy0 === 1'b0);
        end
        chk("t3_hold", 32'(ok), 32'd1);
        chk("t3_level_hold", 32'(level0), 32'd1);
        ctsN = 1'b0;
        waitStart("t3_resume", 5, n);
        frame("t3b", 2, 8'h3C, 1'b0);

        // write lands on the same edge as the last stop tick pop
        wrEn = 1'b1; wrData = 8'hA5;
        @(negedge clk);
        wrData = 8'h5A;
        @(negedge clk);
        wrEn = 1'b0;
        chk("t4_start", 32'(txd0), 32'd0);
        chk("t4_level", 32'(level0), 32'd1);
        repeat (2387) @(negedge clk);
        chk("t4_pre_txd", 32'(txd0), 32'd1);
        chk("t4_pre_level", 32'(level0), 32'd1);
        wrEn = 1'b1; wrData = 8'hE7;
        @(negedge clk);
        wrEn = 1'b0;
        chk("t4_nogap", 32'(txd0), 32'd0);
        chk("t4_level_same", 32'(level0), 32'd1);
        frame("t4b", 2, 8'h5A, 1'b1);
        frame("t4c", 2, 8'hE7, 1'b0);

        // reset during data bit 4 with data queued
        wrEn = 1'b1; wrData = 8'h96;
        @(negedge clk);
        wrData = 8'h44;
        @(negedge clk);
        wrData = 8'h12;
        @(negedge clk);
        wrEn = 1'b0;
        chk("t5_level", 32'(level0), 32'd2);
        repeat (1190) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t5_txd", 32'(txd0), 32'd1);
        chk("t5_busy", 32'(busy0), 32'd0);
        chk("t5_empty", 32'(empty0), 32'd1);
        chk("t5_level0", 32'(level0), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_quiet", 32'(txd0 & ~busy0), 32'd1);
        wrEn = 1'b1; wrData = 8'hA3;
        @(negedge clk);
        wrEn = 1'b0;
        waitStart("t5_start", 4, n);
        frame("t5", 2, 8'hA3, 1'b0);

        // 8N1 build, CTS ignored
        sel = 1'b1;
        wrEn1 = 1'b1; wrData1 = 8'h00;
        @(negedge clk);
        wrData1 = 8'hFF;
        @(negedge clk);
        wrEn1 = 1'b0;
        chk("t6_start", 32'(txd1), 32'd0);
        frame("t6a", 1, 8'h00, 1'b1);
        frame("t6b", 1, 8'hFF, 1'b0);
        chk("t6_empty", 32'(empty1), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
